// File: rtl/fx_accum_dump.sv
// Integrate-and-dump: sums LEN signed samples, then rounds, shifts and
// saturates the frame sum to OUT_W bits with a one-cycle valid strobe.
module fx_accum_dump #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12,
    parameter int LEN   = 8,
    parameter int SHIFT = 3,
    parameter int ACC_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_data,
    input  logic                    i_clear,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_sat
);

    localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    if (LEN < 2) begin : g_len_chk
        $error("fx_accum_dump: LEN must be >= 2");
    end
    if (ACC_W < IN_W + $clog2(LEN)) begin : g_acc_chk
        $error("fx_accum_dump: ACC_W too narrow for IN_W and LEN");
    end

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [OUT_W-1:0]  data_q;
    logic                     valid_q;
    logic                     sat_q;

    logic signed [ACC_W-1:0]  base_d;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W:0]    biased_d;
    logic signed [ACC_W:0]    rnd_d;
    logic signed [OUT_W-1:0]  res_d;
    logic                     clip_d;

    // Bias and shift run one bit wider than the accumulator so +RND never wraps.
    always_comb begin
        base_d   = (state_q == IDLE) ? '0 : acc_q;
        sum_d    = base_d + ACC_W'(i_data);
        biased_d = {sum_d[ACC_W-1], sum_d};
        biased_d = biased_d + RND;
        rnd_d    = biased_d >>> SHIFT;
        res_d    = rnd_d[OUT_W-1:0];
        clip_d   = 1'b0;
        if (rnd_d > MAXV) begin
            res_d  = MAXV[OUT_W-1:0];
            clip_d = 1'b1;
        end else if (rnd_d < MINV) begin
            res_d  = MINV[OUT_W-1:0];
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            if (i_clear) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (i_valid) begin
                if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    data_q  <= res_d;
                    valid_q <= 1'b1;
                    sat_q   <= clip_d;
                end else begin
                    state_q <= ACCUM;
                    acc_q   <= sum_d;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_fx_accum_dump.sv
// Scoreboard bench for fx_accum_dump: default instance plus a SHIFT=0
// instance share stimulus; a bench model queues expected dumps.
module tb_fx_accum_dump;

    logic clk = 1'b0;
    logic rst_n;
    logic i_valid;
    logic i_clear;
    logic [11:0] i_data;

    logic signed [11:0] d0, d1;
    logic v0, v1, s0, s1;

    always #5 clk = ~clk;

    fx_accum_dump u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
        .i_data(i_data), .i_clear(i_clear),
        .o_data(d0), .o_valid(v0), .o_sat(s0)
    );

    fx_accum_dump #(.LEN(8), .SHIFT(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid),
        .i_data(i_data), .i_clear(i_clear),
        .o_data(d1), .o_valid(v1), .o_sat(s1)
    );

    typedef struct {
        int cyc;
        int d0;
        int s0;
        int d1;
        int s1;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_acc = 0;
    int m_cnt = 0;
    int held0 = 0;
    int held1 = 0;
    bit run = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int sum, input int sh,
                                  output int d, output int s);
        int r;
        r = sum;
        if (sh > 0) r = (sum + (1 << (sh - 1))) >>> sh;
        s = 0;
        d = r;
        if (r > 2047) begin
            d = 2047;
            s = 1;
        end else if (r < -2048) begin
            d = -2048;
            s = 1;
        end
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && run) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                check("late", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("v0", v0, 1);
                check("d0", d0, e.d0);
                check("s0", s0, e.s0);
                check("v1", v1, 1);
                check("d1", d1, e.d1);
                check("s1", s1, e.s1);
                held0 = e.d0;
                held1 = e.d1;
            end else begin
                check("v0_idle", v0, 0);
                check("s0_idle", s0, 0);
                check("d0_hold", d0, held0);
                check("v1_idle", v1, 0);
                check("s1_idle", s1, 0);
                check("d1_hold", d1, held1);
            end
        end
    end

    task automatic drive(input logic v, input logic [11:0] d, input logic c);
        exp_t e;
        i_valid = v;
        i_data  = d;
        i_clear = c;
        if (c) begin
            m_acc = 0;
            m_cnt = 0;
        end else if (v) begin
            m_acc += int'($signed(d));
            m_cnt++;
            if (m_cnt == 8) begin
                e.cyc = cyc + 1;
                model(m_acc, 3, e.d0, e.s0);
                model(m_acc, 0, e.d1, e.s1);
                q.push_back(e);
                m_acc = 0;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int n, input int val);
        for (int i = 0; i < n; i++) drive(1'b1, 12'(val), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 'x, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d0"}, d0, 0);
        check({tag, "_v0"}, v0, 0);
        check({tag, "_s0"}, s0, 0);
        check({tag, "_d1"}, d1, 0);
        check({tag, "_v1"}, v1, 0);
        check({tag, "_s1"}, s1, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        run   = 1;

        burst(8, 100);
        idle(3);

        burst(7, 100);
        burst(1, 104);
        idle(2);
        burst(7, -100);
        burst(1, -104);
        idle(2);

        burst(8, -2048);
        idle(2);
        burst(8, 1000);
        idle(2);
        burst(8, -1000);
        idle(2);

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 12'd8, 1'b0);
            drive(1'b0, 'x, 1'b0);
        end
        idle(2);

        for (int k = 0; k < 24; k++) drive(1'b1, 12'(k), 1'b0);
        idle(3);

        burst(5, 50);
        drive(1'b1, 12'd50, 1'b1);
        burst(8, 10);
        idle(3);

        burst(5, 50);
        rst_n = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        q.delete();
        held0 = 0;
        held1 = 0;
        #1;
        check_zero("mid_rst");
        #1;
        rst_n = 1'b1;
        burst(8, 10);
        idle(4);

        check("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx_accum_dump.md
Name: fx_accum_dump

Overview:
- Integrate-and-dump stage that sits directly downstream of the fixed-point adder stage and consumes its registered signed 12-bit sum stream.
- Sums LEN valid samples, then applies a rounded arithmetic right shift (SHIFT) and saturation to OUT_W bits.
- Emits one result per frame with a single-cycle valid strobe.
- Feeds the next fixed-point stage; in datapath it is the decimating partner of the adder.

Parameters:
- IN_W, 12, input sample width, signed two's complement.
- OUT_W, 12, output width, signed two's complement.
- LEN, 8, samples per frame; must be ≥ 2.
- SHIFT, 3, arithmetic right shift applied to the frame sum; 0 means no shift and no rounding.
- ACC_W, 16, accumulator width; must be ≥ IN_W + ceil(log2(LEN)); elaboration error otherwise.

Ports:
- i_clk  input  1  sole clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data carries a sample this cycle.
- i_data  input  IN_W  signed sample (adder stage output).
- i_clear  input  1  synchronous frame abort.
- o_data  output  OUT_W  signed frame result; holds its value between dumps.
- o_valid  output  1  single-cycle strobe; o_data is new this cycle.
- o_sat  output  1  qualified by o_valid; high when the result was clipped.

Behaviour:
- Reset (i_rst_n=0, asynchronous assert, synchronous-safe release):
  - acc=0, cnt=0, state=IDLE, o_data=0, o_valid=0, o_sat=0.
  - Reset mid-frame discards the partial sum. No o_valid follows until LEN new samples arrive.
- States:
  - IDLE: cnt==0, acc==0.
  - ACCUM: 0<cnt<LEN.
  - A dump is a transition, not a state.
- Per cycle, priority is i_clear > i_valid.
- i_clear=1:
  - acc←0, cnt←0, state←IDLE; any same-cycle sample is dropped.
  - o_valid←0 next cycle, even if this would have been the LEN-th sample.
  - o_data is unchanged.
- i_valid=1, cnt<LEN-1:
  - acc←acc+sext(i_data), cnt←cnt+1, state←ACCUM.
- i_valid=1, cnt==LEN-1 (dump):
  - sum = acc + sext(i_data).
  - Next cycle: o_valid=1, o_data=sat(rnd(sum)), o_sat set accordingly.
  - acc←0, cnt←0, state←IDLE.
- i_valid=0 (not a dump cycle): acc and cnt hold; gaps of any length are allowed.
- o_valid is high for exactly one cycle, one cycle after the LEN-th sample clocks in (latency 1).
- Back-to-back frames: a valid sample in the cycle where o_valid=1 is sample 0 of the next frame and is not lost. Continuous valid input yields o_valid once every LEN cycles.
- rnd(x):
  - SHIFT>0: (x + 2^(SHIFT-1)) >>> SHIFT, round half up toward +inf.
  - The addition is computed at ACC_W+1 bits so it cannot wrap.
  - SHIFT=0: x unchanged.
- sat(y):
  - y > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1, o_sat=1.
  - y < -2^(OUT_W-1) → -2^(OUT_W-1), o_sat=1.
  - Otherwise low OUT_W bits of y, o_sat=0.
- o_sat is 0 whenever o_valid=0.
- The accumulator cannot overflow given the ACC_W constraint; no internal wrap handling is required.
- X on i_data while i_valid=0 must not propagate into acc.

Test Plan:
1. Defaults, 8 consecutive samples of +100 → one cycle after the 8th: o_valid=1, o_data=100, o_sat=0; o_valid=0 the following cycle; o_data holds 100.
2. Defaults, samples summing to 804 (seven ×100, one ×104) → o_data=101 (round up); samples summing to -804 → o_data=-100 (half-up toward +inf).
3. Defaults, 8 × -2048 → o_data=-2048, o_sat=0. Override LEN=8, SHIFT=0, 8 × +1000 → o_data=2047, o_sat=1. Same override, 8 × -1000 → o_data=-2048, o_sat=1.
4. Defaults, 16 samples of +8 with i_valid toggling 1,0,1,0… → exactly two o_valid pulses, each o_data=8, each 1 cycle after its 8th valid sample.
5. Defaults, continuous i_valid for 24 cycles with value k in cycle k (k=0..23) → o_valid at cycles 8, 16, 24, with o_data=rnd(28/8)=4, rnd(92/8)=12, rnd(156/8)=20; no sample lost at frame boundaries.
6. Defaults:
   - 5 samples of 50, then i_clear with i_valid=1 on the same cycle, then 8 × 10 → only one o_valid, o_data=10.
   - Repeat with i_rst_n pulsed low after 5 samples instead of i_clear → all outputs 0 immediately, then one o_valid with o_data=10.
